gray_pos_decoder: RTL and testbench



---
 rtl/gray_pos_decoder.sv | 109 ++++++++++
 tb/tb_gray_pos_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gray_pos_decoder.sv
// gray_pos_decoder: decodes a Gray-coded sample stream and tracks a signed
// relative position from single-step movements, counting illegal jumps.
module gray_pos_decoder #(
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [N-1:0]  gray_in,
    output logic          out_vld,
    output logic [N-1:0]  bin_out,
    output logic          step,
    output logic          dir,
    output logic          err,
    output logic          locked,
    output logic [CW-1:0] pos,
    output logic [7:0]    err_cnt
);
    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  prev_q, prev_d, bin_q, bin_d, nb;
    logic [CW-1:0] pos_q, pos_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          vld_q, vld_d, step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic          up, dn;
    int            hd;

    always_comb begin
        nb[N-1] = gray_in[N-1];
        for (int i = N - 2; i >= 0; i--) nb[i] = nb[i+1] ^ gray_in[i];
        hd = 0;
        for (int i = 0; i < N; i++) hd = hd + 32'(gray_in[i] ^ prev_q[i]);
        up = nb == bin_q + N'(1);
        dn = nb == bin_q - N'(1);
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        vld_d   = 1'b0;
        step_d  = 1'b0;
        err_d   = 1'b0;
        if (clr) begin
            state_d = INIT;
            prev_d  = '0;
            pos_d   = '0;
            cnt_d   = '0;
            dir_d   = 1'b0;
        end else if (in_vld) begin
            vld_d  = 1'b1;
            bin_d  = nb;
            prev_d = gray_in;
            if (state_q == INIT) begin
                pos_d   = CW'(nb);
                state_d = TRACK;
            end else if (hd == 1 && up) begin
                step_d = 1'b1;
                dir_d  = 1'b1;
                pos_d  = pos_q + CW'(1);
            end else if (hd == 1 && dn) begin
                step_d = 1'b1;
                dir_d  = 1'b0;
                pos_d  = pos_q - CW'(1);
            end else if (hd != 0) begin
                // any non-adjacent move is a lost step: resync on the new sample
                err_d = 1'b1;
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            prev_q  <= '0;
            bin_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            vld_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            vld_q   <= vld_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign out_vld = vld_q;
    assign bin_out = bin_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign locked  = state_q == TRACK;
    assign pos     = pos_q;
    assign err_cnt = cnt_q;
endmodule

// File: tb/tb_gray_pos_decoder.sv
// tb_gray_pos_decoder: directed stimulus checked every cycle against an
// arithmetic position model, plus literal expectations from the test plan.
module tb_gray_pos_decoder;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int M  = 1 << N;
    localparam int P  = 1 << CW;

    logic          clk = 1'b0, rst = 1'b1, clr = 1'b0, in_vld = 1'b0;
    logic [N-1:0]  gray_in = '0;
    logic          out_vld, step, dir, err, locked;
    logic [N-1:0]  bin_out;
    logic [CW-1:0] pos;
    logic [7:0]    err_cnt;

    int checks = 0, errors = 0;
    int m_bin, m_pos, m_cnt;
    bit m_vld, m_step, m_dir, m_err, m_lock;

    gray_pos_decoder #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .gray_in(gray_in),
        .out_vld(out_vld), .bin_out(bin_out), .step(step), .dir(dir), .err(err),
        .locked(locked), .pos(pos), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int g2b(input logic [N-1:0] g);
        for (int b = 0; b < M; b++) if (N'(b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // position model: movement judged purely from integer code distance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_vld, m_step, m_dir, m_err, m_lock} = '0;
            m_bin = 0; m_pos = 0; m_cnt = 0;
        end else begin
            m_vld = 0; m_step = 0; m_err = 0;
            if (clr) begin
                m_pos = 0; m_cnt = 0; m_dir = 0; m_lock = 0;
            end else if (in_vld) begin
                int nb;
                nb = g2b(gray_in);
                m_vld = 1;
                if (!m_lock) begin
                    m_pos = nb; m_lock = 1;
                end else if (nb == (m_bin + 1) % M) begin
                    m_step = 1; m_dir = 1; m_pos = (m_pos + 1) % P;
                end else if (nb == (m_bin + M - 1) % M) begin
                    m_step = 1; m_dir = 0; m_pos = (m_pos + P - 1) % P;
                end else if (nb != m_bin) begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
                m_bin = nb;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_vld", int'(out_vld), int'(m_vld));
            chk("bin_out", int'(bin_out), m_bin);
            chk("step", int'(step), int'(m_step));
            chk("dir", int'(dir), int'(m_dir));
            chk("err", int'(err), int'(m_err));
            chk("locked", int'(locked), int'(m_lock));
            chk("pos", int'(pos), m_pos);
            chk("err_cnt", int'(err_cnt), m_cnt);
        end
    end

    task automatic send(input logic [N-1:0] g, input logic v, input logic c);
        @(negedge clk);
        gray_in = g; in_vld = v; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_pos", int'(pos), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_vld", int'(out_vld), 0);
        send(4'b0000, 1, 0);
        chk("t1_vld", int'(out_vld), 1);
        chk("t1_bin", int'(bin_out), 0);
        chk("t1_pos", int'(pos), 0);
        chk("t1_locked", int'(locked), 1);
        chk("t1_step", int'(step), 0);
        send(4'b0001, 1, 0);
        chk("t2_bin1", int'(bin_out), 1);
        send(4'b0011, 1, 0);
        chk("t2_bin2", int'(bin_out), 2);
        send(4'b0010, 1, 0);
        chk("t2_bin3", int'(bin_out), 3);
        chk("t2_step", int'(step), 1);
        chk("t2_dir", int'(dir), 1);
        chk("t2_pos", int'(pos), 3);
        send(4'b0000, 0, 1);
        send(4'b1000, 1, 0);
        chk("t3_load_pos", int'(pos), 15);
        send(4'b0000, 1, 0);
        chk("t3_up_bin", int'(bin_out), 0);
        chk("t3_up_dir", int'(dir), 1);
        chk("t3_up_pos", int'(pos), 16);
        send(4'b0000, 0, 1);
        send(4'b0000, 1, 0);
        send(4'b1000, 1, 0);
        chk("t3_dn_dir", int'(dir), 0);
        chk("t3_dn_bin", int'(bin_out), 15);
        chk("t3_dn_pos", int'(pos), 16'hFFFF);
        send(4'b0000, 0, 1);
        send(4'b0000, 1, 0);
        send(4'b0011, 1, 0);
        chk("t4_err", int'(err), 1);
        chk("t4_step", int'(step), 0);
        chk("t4_cnt", int'(err_cnt), 1);
        chk("t4_pos", int'(pos), 0);
        chk("t4_bin", int'(bin_out), 2);
        send(4'b0010, 1, 0);
        chk("t4_rstep", int'(step), 1);
        chk("t4_rbin", int'(bin_out), 3);
        chk("t4_rpos", int'(pos), 1);
        send(4'b0010, 1, 0);
        chk("t5_same_vld", int'(out_vld), 1);
        chk("t5_same_step", int'(step), 0);
        chk("t5_same_err", int'(err), 0);
        chk("t5_same_pos", int'(pos), 1);
        send(4'b0011, 1, 0);
        chk("t5_down_pos", int'(pos), 0);
        for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 4'b0000 : 4'b0011, 1, 0);
        chk("t5_sat", int'(err_cnt), 255);
        send(4'b0000, 0, 0);
        chk("t5_idle_vld", int'(out_vld), 0);
        send(4'b0001, 1, 1);
        chk("t6_clr_pos", int'(pos), 0);
        chk("t6_clr_cnt", int'(err_cnt), 0);
        chk("t6_clr_locked", int'(locked), 0);
        chk("t6_clr_vld", int'(out_vld), 0);
        send(4'b0110, 1, 0);
        send(4'b0111, 1, 0);
        send(4'b0101, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_vld", int'(out_vld), 0);
        chk("t6_arst_bin", int'(bin_out), 0);
        chk("t6_arst_pos", int'(pos), 0);
        chk("t6_arst_locked", int'(locked), 0);
        chk("t6_arst_dir", int'(dir), 0);
        @(negedge clk);
        rst = 1'b0; in_vld = 1'b0;
        send(4'b0100, 1, 0);
        chk("t6_relock_pos", int'(pos), 7);
        send(4'b0000, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
